// File: rtl/rps_spi_rx_if.sv
// rtl/rps_spi_rx_if.sv - frame-side and result-side signals of the RPS SPI receiver
//
// Bundles the chip-select and serial data coming from the MCU together with
// the received word and status flags going to the RPS-to-LED stage.
//   start      frame active (active-high chip select)
//   sdi        serial data, valid at the sck rising edge
//   SIG        last completed payload word
//   done       high from frame completion until the next frame's first bit
//   frame_err  sticky short-frame flag
//   overrun    sticky extra-bits flag
//   parity_err parity result of the last completed frame (0 when parity is off)
// master: MCU/bench side; slave: receiver side.
interface rps_spi_rx_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sdi;
  logic [WIDTH-1:0] SIG;
  logic             done;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;

  modport master (
    output start, sdi,
    input  SIG, done, frame_err, overrun, parity_err
  );

  modport slave (
    input  start, sdi,
    output SIG, done, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/rps_spi_rx.sv
// rtl/rps_spi_rx.sv - SPI peripheral receiver for one RPS gesture word per frame
//
// Shifts a WIDTH-bit word in on bus.sdi while bus.start is high and presents
// it on bus.SIG with bus.done raised on the edge that completes the frame.
// Optional odd-parity bit after the payload: define RPS_RX_PARITY_EN.
// Ports:
//   sck    SPI clock; every state update happens on its rising edge
//   reset  synchronous active-high reset, sampled on the sck rising edge
//   bus    rps_spi_rx_if.slave (start, sdi in; SIG, done, frame_err,
//          overrun, parity_err out)
module rps_spi_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic         sck,
  input logic         reset,
  rps_spi_rx_if.slave bus
);

`ifdef RPS_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int             CW         = $clog2(WIDTH + 2);
  localparam int             FRAME_BITS = WIDTH + PAR_BITS;
  localparam logic [CW-1:0]  FRAME_CNT  = CW'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [WIDTH-1:0] sig_q, sig_n;
  logic             done_q, done_n;
  logic             ferr_q, ferr_n;
  logic             ovr_q, ovr_n;
`ifdef RPS_RX_PARITY_EN
  logic             perr_q, perr_n;
`endif

  // Working values for the bit accepted on this edge.
  logic             take_bit;
  logic [WIDTH-1:0] base_sr;
  logic [CW-1:0]    base_cnt;
  logic [CW-1:0]    cnt_inc;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic b);
    if (MSB_FIRST)
      return {cur[WIDTH-2:0], b};
    else
      return {b, cur[WIDTH-1:1]};
  endfunction

  always_ff @(posedge sck) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      sig_q  <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef RPS_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sr     <= sr_n;
      sig_q  <= sig_n;
      done_q <= done_n;
      ferr_q <= ferr_n;
      ovr_q  <= ovr_n;
`ifdef RPS_RX_PARITY_EN
      perr_q <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sr_n     = sr;
    sig_n    = sig_q;
    done_n   = done_q;
    ferr_n   = ferr_q;
    ovr_n    = ovr_q;
`ifdef RPS_RX_PARITY_EN
    perr_n   = perr_q;
`endif
    take_bit = 1'b0;
    base_sr  = sr;
    base_cnt = cnt;
    cnt_inc  = '0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          // First bit of a new frame: start from a clean word and drop done
          // so the completion of this frame gives a fresh rising edge.
          take_bit = 1'b1;
          base_sr  = '0;
          base_cnt = '0;
          done_n   = 1'b0;
        end
      end
      SHIFT: begin
        if (bus.start) begin
          take_bit = 1'b1;
        end else begin
          // Short frame: keep the last good word, flag it, start over.
          ferr_n  = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      FULL: begin
        if (bus.start) begin
          // Extra bits are discarded; count stays saturated at FRAME_CNT.
          ovr_n = 1'b1;
        end else begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (take_bit) begin
      cnt_inc = base_cnt + 1'b1;
      cnt_n   = cnt_inc;
      if (cnt_inc == FRAME_CNT) begin
        // Frame complete on this edge: publish the word with zero latency.
`ifdef RPS_RX_PARITY_EN
        // The bit on this edge is the parity bit; the payload is already in sr.
        sig_n  = base_sr;
        sr_n   = base_sr;
        perr_n = ~(^{base_sr, bus.sdi});
`else
        sig_n  = shift_in(base_sr, bus.sdi);
        sr_n   = shift_in(base_sr, bus.sdi);
`endif
        done_n  = 1'b1;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;
        state_n = FULL;
      end else begin
        sr_n    = shift_in(base_sr, bus.sdi);
        state_n = SHIFT;
      end
    end
  end

  assign bus.SIG       = sig_q;
  assign bus.done      = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
`ifdef RPS_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rps_spi_rx.sv
// tb/tb_rps_spi_rx.sv - directed scoreboard bench for rps_spi_rx (WIDTH=8, MSB first)
module tb_rps_spi_rx;

  logic sck;
  logic reset;

  rps_spi_rx_if #(.WIDTH(8)) bus ();

  rps_spi_rx #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1)
  ) dut (
    .sck   (sck),
    .reset (reset),
    .bus   (bus)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         rises  = 0;
  logic       prev_done = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sck rising edge with the given inputs; outputs sampled 1 time unit
  // after the edge. Each rising edge of done retires one scoreboard entry.
  task automatic step(input logic s, input logic d, input logic r);
    logic [7:0] e;
    @(negedge sck);
    bus.start = s;
    bus.sdi   = d;
    reset     = r;
    @(posedge sck);
    #1;
    if (r) exp_q.delete();
    if (bus.done && !prev_done) begin
      rises++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done_rise", 32'(bus.SIG), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sig_at_done", 32'(bus.SIG), 32'(e));
      end
    end
    prev_done = bus.done;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) step(1'b1, w[7-i], 1'b0);
  endtask

  // Complete payload (plus correct odd parity when enabled); start left high.
  task automatic frame(input logic [7:0] w);
    exp_q.push_back(w);
    send_bits(w, 8);
`ifdef RPS_RX_PARITY_EN
    step(1'b1, ~^w, 1'b0);
`endif
  endtask

  int rises_before;

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.sdi   = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b1);
    chk("rst_sig", 32'(bus.SIG), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    chk("rst_parity_err", 32'(bus.parity_err), 32'h0);

    // 1: single frame 8'h80, done rises on the last frame edge
    exp_q.push_back(8'h80);
    send_bits(8'h80, 7);
    chk("t1_done_before_last", 32'(bus.done), 32'h0);
    step(1'b1, 1'b0, 1'b0);
`ifdef RPS_RX_PARITY_EN
    chk("t1_done_before_parity", 32'(bus.done), 32'h0);
    step(1'b1, 1'b0, 1'b0);
`endif
    chk("t1_done_last", 32'(bus.done), 32'h1);
    chk("t1_sig", 32'(bus.SIG), 32'h80);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_done_idle", 32'(bus.done), 32'h1);

    // 2: back-to-back frames 8'h40 then 8'h20
    rises_before = rises;
    exp_q.push_back(8'h40);
    step(1'b1, 1'b0, 1'b0);
    chk("t2_done_falls_first_bit", 32'(bus.done), 32'h0);
    send_bits(8'h80, 7);    // remaining bits of 8'h40: 1,0,0,0,0,0,0
`ifdef RPS_RX_PARITY_EN
    step(1'b1, ~^8'h40, 1'b0);
`endif
    chk("t2_sig_a", 32'(bus.SIG), 32'h40);
    step(1'b0, 1'b0, 1'b0);
    frame(8'h20);
    chk("t2_sig_b", 32'(bus.SIG), 32'h20);
    step(1'b0, 1'b0, 1'b0);
    chk("t2_two_rises", 32'(rises - rises_before), 32'd2);

    // Bit ordering with asymmetric patterns
    frame(8'hA5);
    step(1'b0, 1'b0, 1'b0);
    frame(8'h3C);
    step(1'b0, 1'b0, 1'b0);
    chk("order_sig", 32'(bus.SIG), 32'h3C);

    // 3: short frame of 5 bits
    send_bits(8'hFF, 5);
    step(1'b0, 1'b0, 1'b0);
    chk("t3_sig_held", 32'(bus.SIG), 32'h3C);
    chk("t3_done_low", 32'(bus.done), 32'h0);
    chk("t3_frame_err", 32'(bus.frame_err), 32'h1);
    frame(8'h80);
    chk("t3_frame_err_cleared", 32'(bus.frame_err), 32'h0);
    chk("t3_sig", 32'(bus.SIG), 32'h80);
    step(1'b0, 1'b0, 1'b0);

    // 4: two extra bits after the payload
    frame(8'h20);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t4_sig", 32'(bus.SIG), 32'h20);
    chk("t4_done", 32'(bus.done), 32'h1);
    chk("t4_overrun", 32'(bus.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("t4_overrun_sticky", 32'(bus.overrun), 32'h1);
    frame(8'h55);
    chk("t4_overrun_cleared", 32'(bus.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0);

    // 5: reset on the 4th bit of a frame
    send_bits(8'hFF, 3);
    step(1'b1, 1'b1, 1'b1);
    chk("t5_sig", 32'(bus.SIG), 32'h0);
    chk("t5_done", 32'(bus.done), 32'h0);
    chk("t5_frame_err", 32'(bus.frame_err), 32'h0);
    chk("t5_overrun", 32'(bus.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    frame(8'h80);
    chk("t5_sig_after", 32'(bus.SIG), 32'h80);
    chk("t5_done_after", 32'(bus.done), 32'h1);
    step(1'b0, 1'b0, 1'b0);

`ifdef RPS_RX_PARITY_EN
    // 6: odd parity good, then bad
    exp_q.push_back(8'h80);
    send_bits(8'h80, 8);
    step(1'b1, 1'b0, 1'b0);
    chk("t6_parity_ok", 32'(bus.parity_err), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h80);
    send_bits(8'h80, 8);
    step(1'b1, 1'b1, 1'b0);
    chk("t6_parity_bad", 32'(bus.parity_err), 32'h1);
    chk("t6_sig", 32'(bus.SIG), 32'h80);
    chk("t6_done", 32'(bus.done), 32'h1);
    step(1'b0, 1'b0, 1'b0);
`else
    chk("parity_err_off", 32'(bus.parity_err), 32'h0);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
